// File: rtl/video_pkg.sv
// Shared definitions for the packed-RGB video stream blocks.
package video_pkg;

    // Default frame geometry.
    localparam int X_SIZE_DEFAULT = 640;
    localparam int Y_SIZE_DEFAULT = 480;

    // Unpacker states, kept as plain constants so older tools can read them.
    localparam logic [2:0] ST_SYNC  = 3'd0;
    localparam logic [2:0] ST_PH0   = 3'd1;
    localparam logic [2:0] ST_PH1   = 3'd2;
    localparam logic [2:0] ST_PH2   = 3'd3;
    localparam logic [2:0] ST_EXTRA = 3'd4;

    // One pixel; b is the least significant byte on the wire.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/pixel_unpacker.sv
// Receives 32-bit packed RGB words (4 pixels per 3 words), rebuilds 24-bit
// pixels with x/y coordinates, checks line/frame geometry and resyncs on
// malformed lines.
module pixel_unpacker
    import video_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEFAULT,
    parameter int Y_SIZE = Y_SIZE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_stream_tdata,
    input  logic [3:0]  in_stream_tkeep,
    input  logic        in_stream_tlast,
    input  logic        in_stream_tuser,
    input  logic        in_stream_tvalid,
    output logic        in_stream_tready,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_done,
    output logic        err_sof,
    output logic        err_eol_early,
    output logic        err_eol_late,
    output logic [7:0]  err_count,
    input  logic        err_clear
);

    localparam int LW = X_SIZE * 3 / 4;
    localparam int WC_W = (LW > 1) ? $clog2(LW) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(LW - 1);
    localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
    localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

    // Byte enables carry no information: the producer always sends full words.
    logic unused_tkeep;
    assign unused_tkeep = ^in_stream_tkeep;

    logic [2:0]      state_q, state_d;
    logic [23:0]     hold_q, hold_d;
    logic [WC_W-1:0] wc_q, wc_d;
    logic [9:0]      nx_q, nx_d;
    logic [8:0]      ny_q, ny_d;
    pixel_t          pix_q, pix_d;
    logic [9:0]      pix_x_q, pix_x_d;
    logic [8:0]      pix_y_q, pix_y_d;
    logic            sof_q, sof_d;
    logic            eol_q, eol_d;
    logic            valid_q, valid_d;
    logic            live_q;
    logic            err_sof_q, err_sof_d;
    logic            err_early_q, err_early_d;
    logic            err_late_q, err_late_d;
    logic [7:0]      err_count_q, err_count_d;

    logic            out_free;
    logic            tready;
    logic            word_acc;
    logic            at_origin;
    logic            at_line_end;
    logic            emit;
    logic            take_w0;
    logic [9:0]      emit_x;
    logic [8:0]      emit_y;
    pixel_t          new_pix;
    logic            ev_sof, ev_early, ev_late;

    // Handshake qualifiers; live_q keeps tready low while in reset.
    always_comb begin
        out_free    = !valid_q || pix_ready;
        tready      = live_q && (state_q != ST_EXTRA) && out_free;
        word_acc    = in_stream_tvalid && tready;
        at_origin   = (nx_q == 10'd0) && (ny_q == 9'd0) && (wc_q == '0);
        at_line_end = (wc_q == WC_LAST);
    end

    // Word decode, phase sequencing, geometry checks and coordinate tracking.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        wc_d     = wc_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        pix_d    = pix_q;
        pix_x_d  = pix_x_q;
        pix_y_d  = pix_y_q;
        sof_d    = sof_q;
        eol_d    = eol_q;
        valid_d  = valid_q && !pix_ready;
        emit     = 1'b0;
        take_w0  = 1'b0;
        emit_x   = nx_q;
        emit_y   = ny_q;
        new_pix  = pix_q;
        ev_sof   = 1'b0;
        ev_early = 1'b0;
        ev_late  = 1'b0;

        if (word_acc) begin
            if (state_q == ST_SYNC) begin
                take_w0 = in_stream_tuser;
            end else if (in_stream_tuser && !at_origin) begin
                ev_sof  = 1'b1;
                take_w0 = 1'b1;
            end else if (in_stream_tlast && !at_line_end) begin
                ev_early = 1'b1;
                state_d  = ST_SYNC;
                wc_d     = '0;
                nx_d     = 10'd0;
                ny_d     = 9'd0;
            end else if (!in_stream_tlast && at_line_end) begin
                ev_late = 1'b1;
                state_d = ST_SYNC;
                wc_d    = '0;
                nx_d    = 10'd0;
                ny_d    = 9'd0;
            end else begin
                emit = 1'b1;
                wc_d = at_line_end ? '0 : wc_q + WC_W'(1);
                case (state_q)
                    ST_PH0: begin
                        new_pix = in_stream_tdata[23:0];
                        hold_d  = {16'h0000, in_stream_tdata[31:24]};
                        state_d = ST_PH1;
                    end
                    ST_PH1: begin
                        new_pix = {in_stream_tdata[15:8], in_stream_tdata[7:0], hold_q[7:0]};
                        hold_d  = {8'h00, in_stream_tdata[31:16]};
                        state_d = ST_PH2;
                    end
                    ST_PH2: begin
                        new_pix = {in_stream_tdata[7:0], hold_q[15:8], hold_q[7:0]};
                        hold_d  = in_stream_tdata[31:8];
                        state_d = ST_EXTRA;
                    end
                    default: emit = 1'b0;
                endcase
            end
        end else if ((state_q == ST_EXTRA) && out_free) begin
            emit    = 1'b1;
            new_pix = hold_q;
            state_d = ST_PH0;
        end

        // A start-of-frame word always restarts the frame as W0 of pixel (0,0).
        if (take_w0) begin
            emit    = 1'b1;
            emit_x  = 10'd0;
            emit_y  = 9'd0;
            new_pix = in_stream_tdata[23:0];
            hold_d  = {16'h0000, in_stream_tdata[31:24]};
            state_d = ST_PH1;
            wc_d    = WC_W'(1);
        end

        if (emit) begin
            pix_d   = new_pix;
            pix_x_d = emit_x;
            pix_y_d = emit_y;
            sof_d   = (emit_x == 10'd0) && (emit_y == 9'd0);
            eol_d   = (emit_x == X_LAST);
            valid_d = 1'b1;
            if (emit_x == X_LAST) begin
                nx_d = 10'd0;
                ny_d = (emit_y == Y_LAST) ? 9'd0 : emit_y + 9'd1;
            end else begin
                nx_d = emit_x + 10'd1;
                ny_d = emit_y;
            end
        end
    end

    // Sticky error flags and saturating count; a clear beats a same-cycle error.
    always_comb begin
        err_sof_d   = err_sof_q;
        err_early_d = err_early_q;
        err_late_d  = err_late_q;
        err_count_d = err_count_q;
        if (err_clear) begin
            err_sof_d   = 1'b0;
            err_early_d = 1'b0;
            err_late_d  = 1'b0;
            err_count_d = 8'd0;
        end else begin
            if (ev_sof) err_sof_d = 1'b1;
            if (ev_early) err_early_d = 1'b1;
            if (ev_late) err_late_d = 1'b1;
            if ((ev_sof || ev_early || ev_late) && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // Datapath and state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SYNC;
            hold_q  <= 24'd0;
            wc_q    <= '0;
            nx_q    <= 10'd0;
            ny_q    <= 9'd0;
            pix_q   <= '0;
            pix_x_q <= 10'd0;
            pix_y_q <= 9'd0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wc_q    <= wc_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            pix_q   <= pix_d;
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            valid_q <= valid_d;
        end
    end

    // Error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sof_q   <= 1'b0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            err_sof_q   <= err_sof_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
            err_count_q <= err_count_d;
        end
    end

    // Goes high on the first clock after reset so tready starts out low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    assign in_stream_tready = tready;
    assign pix_r            = pix_q.r;
    assign pix_g            = pix_q.g;
    assign pix_b            = pix_q.b;
    assign pix_x            = pix_x_q;
    assign pix_y            = pix_y_q;
    assign pix_sof          = sof_q;
    assign pix_eol          = eol_q;
    assign pix_valid        = valid_q;
    assign frame_done       = valid_q && pix_ready && eol_q && (pix_y_q == Y_LAST);
    assign err_sof          = err_sof_q;
    assign err_eol_early    = err_early_q;
    assign err_eol_late     = err_late_q;
    assign err_count        = err_count_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker at an 8x2 frame size.
module tb_pixel_unpacker;

    localparam int XS   = 8;
    localparam int YS   = 2;
    localparam int LW   = XS * 3 / 4;
    localparam int NPIX = XS * YS;
    localparam int NWRD = LW * YS;

    logic        clk;
    logic        reset;
    logic [31:0] in_stream_tdata;
    logic [3:0]  in_stream_tkeep;
    logic        in_stream_tlast;
    logic        in_stream_tuser;
    logic        in_stream_tvalid;
    logic        in_stream_tready;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof, pix_eol, pix_valid;
    logic        pix_ready;
    logic        frame_done;
    logic        err_sof, err_eol_early, err_eol_late;
    logic [7:0]  err_count;
    logic        err_clear;

    pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_stream_tdata (in_stream_tdata),
        .in_stream_tkeep (in_stream_tkeep),
        .in_stream_tlast (in_stream_tlast),
        .in_stream_tuser (in_stream_tuser),
        .in_stream_tvalid(in_stream_tvalid),
        .in_stream_tready(in_stream_tready),
        .pix_r           (pix_r),
        .pix_g           (pix_g),
        .pix_b           (pix_b),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .pix_sof         (pix_sof),
        .pix_eol         (pix_eol),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .frame_done      (frame_done),
        .err_sof         (err_sof),
        .err_eol_early   (err_eol_early),
        .err_eol_late    (err_eol_late),
        .err_count       (err_count),
        .err_clear       (err_clear)
    );

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         x;
        int         y;
        bit         sof;
        bit         eol;
    } pixRec_t;

    typedef struct {
        int      idx;
        pixRec_t pix;
    } keyVec_t;

    pixRec_t pixQ[$];
    keyVec_t keyTab[7];
    int      testsRun;
    int      failures;
    int      cycle;
    int      frameDoneCount;
    int      readyViolations;
    int      lastAccept;
    int      firstAccept;
    bit      backpressure;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time word acceptance.
    always @(posedge clk) cycle <= cycle + 1;

    // Consumer ready: always ready, or coin-flip when backpressure is on.
    always @(posedge clk) begin
        #1;
        pix_ready = backpressure ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Capture pixel handshakes, frame_done pulses and tready rule breaks mid-cycle.
    always @(negedge clk) begin
        if (!reset && pix_valid && pix_ready) begin
            pixQ.push_back('{r: pix_r, g: pix_g, b: pix_b, x: int'(pix_x), y: int'(pix_y),
                             sof: pix_sof, eol: pix_eol});
        end
        if (frame_done) frameDoneCount++;
        if (pix_valid && !pix_ready && in_stream_tready) readyViolations++;
    end

    function automatic logic [63:0] packRec(pixRec_t p);
        logic [9:0] xv;
        logic [8:0] yv;
        xv = 10'(p.x);
        yv = 9'(p.y);
        return {19'd0, p.r, p.g, p.b, xv, yv, p.sof, p.eol};
    endfunction

    // Reference pixel i of a frame whose byte stream starts at base.
    function automatic pixRec_t expPix(int base, int i);
        pixRec_t p;
        p.b   = 8'(base + 3 * i);
        p.g   = 8'(base + 3 * i + 1);
        p.r   = 8'(base + 3 * i + 2);
        p.x   = i % XS;
        p.y   = i / XS;
        p.sof = (i == 0);
        p.eol = ((i % XS) == XS - 1);
        return p;
    endfunction

    function automatic logic [31:0] wordOf(int base, int k);
        return {8'(base + 4 * k + 3), 8'(base + 4 * k + 2), 8'(base + 4 * k + 1), 8'(base + 4 * k)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one word and hold it until accepted (bounded); call at posedge+1.
    task automatic applyStimulus(input logic [31:0] d, input logic u, input logic l);
        int n;
        n = 0;
        in_stream_tdata  = d;
        in_stream_tuser  = u;
        in_stream_tlast  = l;
        in_stream_tvalid = 1'b1;
        @(negedge clk);
        while (!in_stream_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_stream_tready) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL word_accept_timeout: tready got 0 expected 1");
        end else begin
            lastAccept = cycle;
        end
        @(posedge clk);
        #1;
        in_stream_tvalid = 1'b0;
        in_stream_tuser  = 1'b0;
        in_stream_tlast  = 1'b0;
    endtask

    task automatic sendFrame(input int base);
        for (int k = 0; k < NWRD; k++) begin
            applyStimulus(wordOf(base, k), k == 0, (k % LW) == LW - 1);
            if (k == 0) firstAccept = lastAccept;
        end
    endtask

    task automatic waitPixels(input int n);
        int t;
        t = 0;
        while (pixQ.size() < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic toDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic checkFrame(input string name, input int start, input int base);
        logic [63:0] act;
        for (int i = 0; i < NPIX; i++) begin
            act = (start + i < pixQ.size()) ? packRec(pixQ[start + i]) : '1;
            checkOutput($sformatf("%s_pix%0d", name, i), act, packRec(expPix(base, i)));
        end
    endtask

    task automatic pulseClear();
        err_clear = 1'b1;
        toDrive();
        err_clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int fd0;
        testsRun         = 0;
        failures         = 0;
        cycle            = 0;
        frameDoneCount   = 0;
        readyViolations  = 0;
        backpressure     = 1'b0;
        reset            = 1'b1;
        in_stream_tdata  = '0;
        in_stream_tkeep  = 4'hF;
        in_stream_tlast  = 1'b0;
        in_stream_tuser  = 1'b0;
        in_stream_tvalid = 1'b0;
        pix_ready        = 1'b1;
        err_clear        = 1'b0;

        // Hand-computed pixels of a frame carrying bytes 0..47.
        keyTab[0] = '{0,  '{r: 2,  g: 1,  b: 0,  x: 0, y: 0, sof: 1, eol: 0}};
        keyTab[1] = '{1,  '{r: 5,  g: 4,  b: 3,  x: 1, y: 0, sof: 0, eol: 0}};
        keyTab[2] = '{3,  '{r: 11, g: 10, b: 9,  x: 3, y: 0, sof: 0, eol: 0}};
        keyTab[3] = '{4,  '{r: 14, g: 13, b: 12, x: 4, y: 0, sof: 0, eol: 0}};
        keyTab[4] = '{7,  '{r: 23, g: 22, b: 21, x: 7, y: 0, sof: 0, eol: 1}};
        keyTab[5] = '{8,  '{r: 26, g: 25, b: 24, x: 0, y: 1, sof: 0, eol: 0}};
        keyTab[6] = '{15, '{r: 47, g: 46, b: 45, x: 7, y: 1, sof: 0, eol: 1}};

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_tready", in_stream_tready, 0);
        checkOutput("rst_valid", pix_valid, 0);
        checkOutput("rst_pixel", {pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol}, 0);
        checkOutput("rst_errs", {err_sof, err_eol_early, err_eol_late, err_count, frame_done}, 0);
        reset = 1'b0;
        toDrive();

        // Clean frame, no stalls.
        $display("[TB] clean frame");
        fd0 = frameDoneCount;
        sendFrame(0);
        checkOutput("clean_word_span", lastAccept - firstAccept, 14);
        waitPixels(NPIX);
        checkOutput("clean_count", pixQ.size(), NPIX);
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("clean_key%0d", keyTab[i].idx),
                        (keyTab[i].idx < pixQ.size()) ? packRec(pixQ[keyTab[i].idx]) : '1,
                        packRec(keyTab[i].pix));
        end
        checkFrame("clean", 0, 0);
        checkOutput("clean_frame_done", frameDoneCount - fd0, 1);
        checkOutput("clean_errs", {err_sof, err_eol_early, err_eol_late, err_count}, 0);

        // Same frame under random consumer backpressure.
        $display("[TB] backpressure");
        pixQ.delete();
        backpressure = 1'b1;
        fd0 = frameDoneCount;
        toDrive();
        sendFrame(0);
        waitPixels(NPIX);
        backpressure = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("bp_count", pixQ.size(), NPIX);
        checkFrame("bp", 0, 0);
        checkOutput("bp_frame_done", frameDoneCount - fd0, 1);
        checkOutput("bp_tready_rule", readyViolations, 0);

        // Reset in the middle of a line clears outputs at once.
        $display("[TB] mid-line reset and leading garbage");
        toDrive();
        for (int k = 0; k < 4; k++) applyStimulus(wordOf(200, k), k == 0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_valid", pix_valid, 0);
        checkOutput("async_rst_tready", in_stream_tready, 0);
        checkOutput("async_rst_pixel", {pix_r, pix_g, pix_b, pix_x}, 0);
        @(negedge clk);
        reset = 1'b0;
        pixQ.delete();
        toDrive();
        for (int k = 0; k < 5; k++) applyStimulus(wordOf(150, k), 1'b0, k == 2);
        sendFrame(100);
        waitPixels(NPIX);
        checkOutput("garbage_count", pixQ.size(), NPIX);
        checkFrame("garbage", 0, 100);
        checkOutput("garbage_errs", {err_sof, err_eol_early, err_eol_late, err_count}, 0);

        // Early tlast at wc=3.
        $display("[TB] early eol");
        pixQ.delete();
        toDrive();
        for (int k = 0; k < 4; k++) applyStimulus(wordOf(0, k), k == 0, k == 3);
        applyStimulus(wordOf(80, 0), 1'b0, 1'b0);
        applyStimulus(wordOf(80, 1), 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("early_flags", {err_sof, err_eol_early, err_eol_late}, 3'b010);
        checkOutput("early_count", err_count, 1);
        checkOutput("early_pixels", pixQ.size(), 4);
        pixQ.delete();
        toDrive();
        sendFrame(0);
        waitPixels(NPIX);
        checkOutput("early_resync_count", pixQ.size(), NPIX);
        checkFrame("early_resync", 0, 0);

        // Missing tlast at the end of a line.
        $display("[TB] late eol");
        toDrive();
        pulseClear();
        checkOutput("clear_flags", {err_sof, err_eol_early, err_eol_late, err_count}, 0);
        pixQ.delete();
        toDrive();
        for (int k = 0; k < LW; k++) applyStimulus(wordOf(0, k), k == 0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("late_flags", {err_sof, err_eol_early, err_eol_late}, 3'b001);
        checkOutput("late_count", err_count, 1);
        checkOutput("late_pixels", pixQ.size(), 6);
        pixQ.delete();
        toDrive();
        sendFrame(0);
        waitPixels(NPIX);
        checkFrame("late_resync", 0, 0);

        // tuser mid-line restarts the frame on that very word.
        $display("[TB] mid-line sof");
        pixQ.delete();
        fd0 = frameDoneCount;
        toDrive();
        for (int k = 0; k < 3; k++) applyStimulus(wordOf(0, k), k == 0, 1'b0);
        sendFrame(60);
        waitPixels(NPIX + 4);
        checkOutput("sof_flags", {err_sof, err_eol_early, err_eol_late}, 3'b101);
        checkOutput("sof_count", err_count, 2);
        checkOutput("sof_total", pixQ.size(), NPIX + 4);
        checkFrame("sof_restart", 4, 60);
        checkOutput("sof_frame_done", frameDoneCount - fd0, 1);

        // Error counter saturation and clear priority.
        $display("[TB] saturation");
        toDrive();
        pulseClear();
        toDrive();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(wordOf(0, 0), 1'b1, 1'b0);
            applyStimulus(wordOf(0, 1), 1'b0, 1'b1);
            if (i == 199) checkOutput("sat_count200", err_count, 200);
        end
        @(negedge clk);
        checkOutput("sat_count", err_count, 255);
        checkOutput("sat_flags", {err_sof, err_eol_early, err_eol_late}, 3'b010);
        toDrive();
        err_clear = 1'b1;
        applyStimulus(wordOf(0, 0), 1'b1, 1'b0);
        applyStimulus(wordOf(0, 1), 1'b0, 1'b1);
        err_clear = 1'b0;
        @(negedge clk);
        checkOutput("clear_wins", {err_sof, err_eol_early, err_eol_late, err_count}, 0);
        checkOutput("final_tready_rule", readyViolations, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
